// File: rtl/ncnet_decimator.sv
// rtl/ncnet_decimator.sv - sum-and-dump / sinc2 decimator for the DDSM adder-network stream (NCNET_DEC_SINC2_EN selects sinc2)
module ncnet_decimator #(
    parameter int P_IN_WIDTH = 4,
    parameter int P_DEC_LOG2 = 4,
`ifdef NCNET_DEC_SINC2_EN
    localparam int L_OUT_W = P_IN_WIDTH + 2 * P_DEC_LOG2
`else
    localparam int L_OUT_W = P_IN_WIDTH + P_DEC_LOG2
`endif
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_en,
    input  logic [P_IN_WIDTH-1:0] i_din,
    input  logic                  i_ready,
    output logic [L_OUT_W-1:0]    o_dout,
    output logic                  o_valid,
    output logic                  o_ovr
);

    logic [P_DEC_LOG2-1:0] cnt_q;
    logic [P_DEC_LOG2-1:0] cnt_d;
    logic                  dump;
    logic [L_OUT_W-1:0]    x;
    logic [L_OUT_W-1:0]    result;
    logic [L_OUT_W-1:0]    dout_q;
    logic                  valid_q;
    logic                  ovr_q;

    // The counter is a power-of-two width, so the last sample of a block
    // is the all-ones count and the increment wraps to 0 by itself.
    assign cnt_d = cnt_q + 1'b1;
    assign dump  = i_en && (cnt_q == {P_DEC_LOG2{1'b1}});
    assign x     = {{(L_OUT_W - P_IN_WIDTH){i_din[P_IN_WIDTH-1]}}, i_din};

    // Sample counter, advanced by each valid input sample
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q <= '0;
        end else if (i_en) begin
            cnt_q <= cnt_d;
        end
    end

`ifdef NCNET_DEC_SINC2_EN
    logic [L_OUT_W-1:0] int1_q, int2_q, d1_q, d2_q;
    logic [L_OUT_W-1:0] int1_d, int2_d, c1;

    assign int1_d = int1_q + x;
    assign int2_d = int2_q + int1_d;
    assign c1     = int2_d - d1_q;
    assign result = c1 - d2_q;

    // Two free-running integrators at the input rate; wrap-around is harmless
    // because the combs difference it out modulo 2^L_OUT_W.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            int1_q <= '0;
            int2_q <= '0;
        end else if (i_en) begin
            int1_q <= int1_d;
            int2_q <= int2_d;
        end
    end

    // Two comb delay registers, updated only at the decimated rate
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            d1_q <= '0;
            d2_q <= '0;
        end else if (dump) begin
            d1_q <= int2_d;
            d2_q <= c1;
        end
    end
`else
    logic [L_OUT_W-1:0] acc_q;
    logic [L_OUT_W-1:0] acc_d;

    assign acc_d  = acc_q + x;
    assign result = acc_d;

    // Block accumulator; the dump sample is folded into the result and the
    // accumulator restarts from zero for the next block.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            acc_q <= '0;
        end else if (i_en) begin
            acc_q <= dump ? '0 : acc_d;
        end
    end
`endif

    // Output holding register with valid/ready handshake and overrun pulse
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            dout_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            ovr_q <= dump && valid_q && !i_ready;
            if (dump) begin
                dout_q  <= result;
                valid_q <= 1'b1;
            end else if (valid_q && i_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign o_dout  = dout_q;
    assign o_valid = valid_q;
    assign o_ovr   = ovr_q;

endmodule
